// File: rtl/ublock_inv_sbox_layer_pkg.sv
// Shared uBlock definitions: S-box tables, inverse-layer FSM states and beat-count helper.
package ublock_inv_sbox_layer_pkg;

  // Nibble i of each table holds S(i) / InvS(i) in bits [4i+3:4i].
  localparam logic [63:0] INV_SBOX_TABLE = 64'h8963_4527_0BF1_DEAC;
  localparam logic [63:0] FWD_SBOX_TABLE = 64'h5230_61EF_8DAB_C947;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned beats(input int unsigned width, input int unsigned lanes);
    return width / (4 * lanes);
  endfunction

endpackage

// File: rtl/ublock_inv_sbox.sv
// 4-bit combinational uBlock inverse S-box; table form, a stand-in for a future gate-level netlist.
module ublock_inv_sbox
  import ublock_inv_sbox_layer_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble_c
);

  logic [5:0] w_idx;

  assign w_idx      = {i_nibble, 2'b00};
  assign o_nibble_c = INV_SBOX_TABLE[w_idx +: 4];

endmodule

// File: rtl/ublock_inv_sbox_layer.sv
// Serial inverse S-box layer: loads a state, substitutes LANES nibbles per beat while
// rotating the state right, then presents the result until downstream takes it.
module ublock_inv_sbox_layer
  import ublock_inv_sbox_layer_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned LANES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned BEATS   = beats(WIDTH, LANES);
  localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SLICE_W = 4 * LANES;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [WIDTH-1:0]   w_rot;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SLICE_W-1:0] w_sub;

  // Inverse S-box lanes on the low slice of the shift register.
  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    ublock_inv_sbox u_inv_sbox (
      .i_nibble   (r_shift[4*l +: 4]),
      .o_nibble_c (w_sub[4*l +: 4])
    );
  end

  // Substituted slice re-enters at the top so nibbles land back in place after BEATS shifts.
  if (BEATS == 1) begin : g_rot_full
    assign w_rot = w_sub;
  end else begin : g_rot_shift
    assign w_rot = {w_sub, r_shift[WIDTH-1:SLICE_W]};
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_shift_nxt = in_data;
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_shift_nxt = w_rot;
        if (r_cnt == LAST_BEAT) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ublock_inv_sbox_layer.sv
// Self-checking bench for ublock_inv_sbox_layer: directed vectors, handshake corners and
// forward/inverse round trips over several WIDTH/LANES configurations.
module tb_ublock_inv_sbox_layer;

  localparam int unsigned W    = 128;
  localparam int unsigned NV   = 1000;
  localparam int          NVAR = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];

  logic         v_iv[NVAR];
  logic         v_ir[NVAR];
  logic         v_ov[NVAR];
  logic [255:0] v_id[NVAR];
  logic [255:0] v_od[NVAR];
  logic [255:0] v_sb[NVAR][$];

  always #5 clk = ~clk;

  function automatic int unsigned vw(input int g);
    return (g < 4) ? 128 : 256;
  endfunction

  function automatic int unsigned vl(input int g);
    case (g % 4)
      0:       return 1;
      1:       return 4;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  ublock_inv_sbox_layer #(.WIDTH(W), .LANES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  for (genvar g = 0; g < NVAR; g++) begin : g_var
    localparam int unsigned GW = vw(g);
    logic [GW-1:0] l_out;
    logic          l_rdy;
    logic          l_ov;
    ublock_inv_sbox_layer #(.WIDTH(GW), .LANES(vl(g))) u_var (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_iv[g]),
      .in_ready  (l_rdy),
      .in_data   (v_id[g][GW-1:0]),
      .out_valid (l_ov),
      .out_ready (1'b1),
      .out_data  (l_out)
    );
    assign v_ir[g] = l_rdy;
    assign v_ov[g] = l_ov;
    assign v_od[g] = 256'(l_out);
  end

  function automatic logic [255:0] fwd_model(input logic [255:0] x);
    logic [63:0]  t;
    logic [255:0] r;
    int           idx;
    t = ublock_inv_sbox_layer_pkg::FWD_SBOX_TABLE;
    for (int i = 0; i < 64; i++) begin
      idx = 4 * int'(x[4*i +: 4]);
      r[4*i +: 4] = t[idx +: 4];
    end
    return r;
  endfunction

  // Inverse computed by searching the forward table, independent of the inverse table.
  function automatic logic [W-1:0] inv_model(input logic [W-1:0] x);
    logic [63:0]  t;
    logic [W-1:0] r;
    t = ublock_inv_sbox_layer_pkg::FWD_SBOX_TABLE;
    r = '0;
    for (int i = 0; i < int'(W / 4); i++) begin
      for (int j = 0; j < 16; j++) begin
        if (t[4*j +: 4] == x[4*i +: 4]) r[4*i +: 4] = 4'(j);
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one state into the main DUT from IDLE, wait for the result and consume it.
  task automatic run_one(input logic [W-1:0] d, output logic [W-1:0] got,
                         output int lat, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ok  = out_valid;
    got = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL reset_out_data got=%h exp=0", out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] d, input logic [W-1:0] e);
    logic [W-1:0] got, exp;
    int lat;
    bit ok;
    sb.push_back(e);
    run_one(d, got, lat, ok);
    exp = sb.pop_front();
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_timeout out_valid never rose", name);
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL %s_latency got=%0d exp=4", name, lat);
    end
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s_data got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_random_model;
    logic [W-1:0] d, got, exp;
    int lat;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      d = rand128();
      sb.push_back(inv_model(d));
      run_one(d, got, lat, ok);
      exp = sb.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        errors++; $display("FAIL random_%0d got=%h exp=%h valid=%b", i, got, exp, ok);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] a, b, exp_a, exp_b;
    int lat;
    a = rand128();
    b = rand128();
    out_ready = 1'b0;
    sb.push_back(inv_model(a));
    in_valid = 1'b1;
    in_data  = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++; $display("FAIL bp_first_timeout out_valid never rose");
    end
    exp_a = sb.pop_front();
    in_valid = 1'b1;
    in_data  = b;
    sb.push_back(inv_model(b));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_data !== exp_a || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d data=%h exp=%h in_ready=%b exp=0 out_valid=%b exp=1",
                 i, out_data, exp_a, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release in_ready=%b exp=1 out_valid=%b exp=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_load in_ready=%b exp=0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_b = sb.pop_front();
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL bp_second_latency got=%0d exp=4", lat);
    end
    checks++;
    if (out_data !== exp_b) begin
      errors++; $display("FAIL bp_second_data got=%h exp=%h", out_data, exp_b);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] a, b, got, exp;
    int lat;
    int seen;
    bit ok;
    a = rand128();
    b = rand128();
    sb.push_back(inv_model(a));
    in_valid = 1'b1;
    in_data  = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags in_ready=%b exp=1 out_valid=%b exp=0", in_ready, out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL rstmid_data got=%h exp=0", out_data);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rstmid_ghost out_valid_cycles=%0d exp=0", seen);
    end
    sb.push_back(inv_model(b));
    run_one(b, got, lat, ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || got !== exp || lat != 4) begin
      errors++; $display("FAIL rstmid_next got=%h exp=%h lat=%0d exp_lat=4", got, exp, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] d[6];
    logic [W-1:0] exp;
    int sent, got, last, cyc;
    logic prev_rdy;
    for (int i = 0; i < 6; i++) d[i] = rand128();
    out_ready = 1'b1;
    sent = 0;
    got  = 0;
    last = 0;
    cyc  = 0;
    in_valid = 1'b1;
    in_data  = d[0];
    sb.push_back(inv_model(d[0]));
    prev_rdy = in_ready;
    while (got < 6 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (in_valid && prev_rdy) begin
        sent++;
        if (sent < 6) begin
          in_data = d[sent];
          sb.push_back(inv_model(d[sent]));
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected output data=%h", out_data);
        end else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin
            errors++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", got, out_data, exp);
          end
        end
        if (got > 0) begin
          checks++;
          if (cyc - last != 6) begin
            errors++; $display("FAIL b2b_interval idx=%0d got=%0d exp=6", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      prev_rdy = in_ready;
    end
    checks++;
    if (got != 6) begin
      errors++; $display("FAIL b2b_count got=%0d exp=6", got);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_round_trip;
    int sent[NVAR];
    int rcvd[NVAR];
    int cyc;
    bit busy;
    logic [255:0] plain, exp, mask;
    for (int k = 0; k < NVAR; k++) begin
      sent[k] = 0;
      rcvd[k] = 0;
      v_sb[k].delete();
    end
    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < 90000) begin
      @(posedge clk); #1;
      cyc++;
      busy = 1'b0;
      for (int k = 0; k < NVAR; k++) begin
        mask = (vw(k) == 256) ? {256{1'b1}} : {128'd0, {128{1'b1}}};
        if (v_iv[k]) begin
          v_iv[k] = 1'b0;
          sent[k]++;
        end
        if (v_ov[k]) begin
          checks++;
          if (v_sb[k].size() == 0) begin
            errors++; $display("FAIL rt_unexpected cfg=%0d data=%h", k, v_od[k]);
          end else begin
            exp = v_sb[k].pop_front();
            if (v_od[k] !== exp) begin
              errors++; $display("FAIL rt_data cfg=%0d w=%0d lanes=%0d got=%h exp=%h",
                                 k, vw(k), vl(k), v_od[k], exp);
            end
          end
          rcvd[k]++;
        end
        if (!v_iv[k] && sent[k] < int'(NV) && v_ir[k]) begin
          plain = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()} & mask;
          v_id[k] = fwd_model(plain) & mask;
          v_iv[k] = 1'b1;
          v_sb[k].push_back(plain);
        end
        if (rcvd[k] < int'(NV)) busy = 1'b1;
      end
    end
    for (int k = 0; k < NVAR; k++) begin
      checks++;
      if (rcvd[k] != int'(NV)) begin
        errors++; $display("FAIL rt_count cfg=%0d got=%0d exp=%0d", k, rcvd[k], NV);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NVAR; k++) begin
      v_iv[k] = 1'b0;
      v_id[k] = '0;
    end
    test_reset();
    test_directed("zero", 128'h0, 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC);
    test_directed("ramp", 128'h0123456789ABCDEF_FEDCBA9876543210,
                  128'hCAED1FB072543698_896345270BF1DEAC);
    test_random_model();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
